// File: rtl/boton_antirebote_multi.sv
// Multi-channel button debouncer: 2-flop sync, symmetric MIN_TIME filter, press/release/long/repeat pulses.
// Latency: level and edge pulses MIN_TIME+2 clk after a steady pin change; no backpressure (free-running).
module boton_antirebote_multi #(
  parameter int N_BTN       = 4,
  parameter int MIN_TIME    = 5000,
  parameter int LONG_TIME   = 1000000,
  parameter int REPEAT_TIME = 250000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam int   CW   = $clog2(MIN_TIME + 1);
  localparam int   HW   = $clog2(LONG_TIME + 1);
  localparam int   RW   = (REPEAT_TIME > 1) ? $clog2(REPEAT_TIME) : 1;
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync;
    logic          r;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          flip;
    logic          holding;
    logic          lvl, prs, rls, lng;

    assign r          = sync[1] ^ IDLE;
    assign flip       = (r != lvl) && (cnt == CW'(MIN_TIME - 1));
    assign rise[i]    = flip & r;
    assign fall[i]    = flip & ~r;
    // Still pressed after this edge; a release edge suppresses long/repeat in its own cycle.
    assign holding    = lvl & ~fall[i];

    assign btn_level[i]   = lvl;
    assign btn_press[i]   = prs;
    assign btn_release[i] = rls;
    assign btn_long[i]    = lng;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= {2{IDLE}};
        cnt  <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
      end else begin
        sync <= {sync[0], btn_in[i]};
        prs  <= rise[i];
        rls  <= fall[i];
        if (r == lvl || flip) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
        if (flip) lvl <= r;
      end
    end

    // hcnt saturates at LONG_TIME, which doubles as the "long already fired" flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt <= '0;
        lng  <= 1'b0;
      end else begin
        lng <= holding && (hcnt == HW'(LONG_TIME - 1));
        if (!holding)                    hcnt <= '0;
        else if (hcnt != HW'(LONG_TIME)) hcnt <= hcnt + HW'(1);
      end
    end

    if (REPEAT_TIME > 0) begin : g_rep
      logic [RW-1:0] rcnt;
      logic          rep;

      assign btn_repeat[i] = rep;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt <= '0;
          rep  <= 1'b0;
        end else begin
          rep <= 1'b0;
          if (!holding) begin
            rcnt <= '0;
          end else if (hcnt == HW'(LONG_TIME)) begin
            if (rcnt == RW'(REPEAT_TIME - 1)) begin
              rcnt <= '0;
              rep  <= 1'b1;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end
      end
    end else begin : g_norep
      assign btn_repeat[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |rise;
  end

endmodule

// File: doc/boton_antirebote_multi.md
Name: boton_antirebote_multi

Overview:
Multi-channel, parametrised button debouncer; successor to the single-button debouncer used on the board pushbuttons. Each channel synchronises its raw input, filters bounce symmetrically on press and release, and exports a clean level plus one-cycle press, release, long-press and auto-repeat event pulses. Sits between the board pins and the control FSMs, replacing one debouncer instance per button.

Parameters:
N_BTN, 4, number of independent button channels (>=1)
MIN_TIME, 5000, clk cycles the synchronised input must differ from the debounced level before the level flips (>=1)
LONG_TIME, 1000000, clk cycles the debounced level must stay pressed before btn_long fires (>MIN_TIME)
REPEAT_TIME, 250000, period in clk cycles of btn_repeat after btn_long; 0 disables auto-repeat
ACTIVE_LOW, 0, 1 = raw inputs are pressed-when-0 (inverted after synchronisation)

Ports:
clk  input  1  system clock; all timing counted in clk cycles
rst_n  input  1  asynchronous, active-low reset
btn_in  input  N_BTN  raw asynchronous button pins, bit i = channel i
btn_level  output  N_BTN  debounced level, 1 = pressed (polarity-normalised)
btn_press  output  N_BTN  1-cycle pulse on debounced press
btn_release  output  N_BTN  1-cycle pulse on debounced release
btn_long  output  N_BTN  1-cycle pulse when held LONG_TIME cycles
btn_repeat  output  N_BTN  1-cycle pulses every REPEAT_TIME cycles after btn_long while held
any_press  output  1  registered OR of btn_press (same cycle as btn_press)

Behaviour:
- Reset (rst_n=0, async): all outputs 0; sync flops load the released level (0 after normalisation); all counters 0. Reset mid-count discards progress; after release the channel restarts from released state.
- Per channel, fully independent; no shared state except any_press.
- Sync: 2-flop synchroniser per bit; r = sync2 XOR ACTIVE_LOW.
- Debounce counter cnt, width $clog2(MIN_TIME+1): r==btn_level -> cnt<=0; r!=btn_level -> cnt<=cnt+1; when cnt==MIN_TIME-1 and r!=btn_level -> btn_level<=r, cnt<=0.
- Latency: first rising edge that samples a new pin value = edge 1; btn_level changes on edge MIN_TIME+2 if pin held steady. Applies equally to press and release.
- Glitch: any return of r to btn_level before count completes clears cnt; pulses shorter than MIN_TIME cycles (post-sync) never change btn_level.
- btn_press / btn_release: high exactly one cycle, registered, in the same cycle btn_level goes 1 / 0. Never both high together on one channel.
- Hold counter hcnt (width $clog2(LONG_TIME+1)): 0 while btn_level=0; increments each cycle btn_level=1; btn_long pulses when hcnt==LONG_TIME-1, i.e. LONG_TIME cycles after btn_level rose. Fires once per press; hcnt saturates.
- Repeat (REPEAT_TIME!=0): after btn_long, rcnt counts; btn_repeat pulses every REPEAT_TIME cycles (first at LONG_TIME+REPEAT_TIME after rise) until release. btn_long cycle is not a btn_repeat.
- Release at any point clears hcnt/rcnt in the release cycle; no long/repeat pulse in or after the release cycle. Release one cycle before LONG_TIME -> no btn_long.
- Re-press: full MIN_TIME debounce again; hold timing restarts.
- any_press: OR-reduction of btn_press, same cycle.

Test Plan:
- N_BTN=2, MIN_TIME=4, LONG_TIME=20, REPEAT_TIME=6, ACTIVE_LOW=0 for all unless stated.
- Glitch: btn_in[0] high 3 cycles then low -> btn_level, btn_press stay 0; btn_in[0] high 4 cycles -> btn_level[0] rises on edge 6, btn_press[0] and any_press high that one cycle.
- Bouncy release: held >=40 cycles then low/high/low toggles every 2 cycles then low -> exactly one btn_release[0], MIN_TIME+2 edges after last toggle.
- Long/repeat: hold 40 cycles post-rise -> btn_long[0] 20 cycles after rise, btn_repeat[0] at 26, 32, 38; release -> no further pulses.
- Channel independence + REPEAT_TIME=0: press ch0 and ch1 2 cycles apart -> two distinct press pulses at correct offsets; no btn_repeat ever.
- ACTIVE_LOW=1: pins idle 1 after reset -> btn_level=0; pin driven 0 for 10 cycles -> btn_press at edge 6.
- Reset mid-count: rst_n low at cnt=3 -> outputs 0 immediately; after deassert, held input needs full MIN_TIME+2 edges.
